// File: rtl/seq_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_mult                                                     |
// | Description : Sequential shift-add multiplier, W-bit operands, 2W-bit      |
// |               product, signed or unsigned per operation.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_mult #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] res
);

    localparam int                 c_CNT_W    = $clog2(W);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(W - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [W-1:0]       r_mcand;
    logic [W-1:0]       r_mplier;
    logic               r_neg;
    logic [2*W-1:0]     r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [2*W-1:0]     r_res;

    logic [W-1:0]       w_a_mag;
    logic [W-1:0]       w_b_mag;
    logic [2*W-1:0]     w_pp;
    logic [2*W-1:0]     w_acc_next;

    // The magnitude of the most negative value still fits in W unsigned bits.
    assign w_a_mag    = (sgn && a[W-1]) ? -a : a;
    assign w_b_mag    = (sgn && b[W-1]) ? -b : b;
    assign w_pp       = {{W{1'b0}}, r_mcand} << r_cnt;
    assign w_acc_next = r_mplier[0] ? (r_acc + w_pp) : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_res    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_neg    <= sgn & (a[W-1] ^ b[W-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_LAST) begin
                        r_res   <= r_neg ? -w_acc_next : w_acc_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign res  = r_res;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_mult                                                  |
// | Description : Scoreboard bench for seq_mult at W=8, W=5 and W=16.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // W=8 instance
    logic        rst8 = 1'b1, start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] res8;
    // W=5 and W=16 instances share a reset
    logic        rst_x = 1'b1;
    logic        start5 = 1'b0, sgn5 = 1'b0;
    logic [4:0]  a5 = '0, b5 = '0;
    logic        busy5, done5;
    logic [9:0]  res5;
    logic        start16 = 1'b0, sgn16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] res16;

    seq_mult #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .res(res8)
    );
    seq_mult #(.W(5)) u_dut5 (
        .clk(clk), .rst(rst_x), .start(start5), .sgn(sgn5), .a(a5), .b(b5),
        .busy(busy5), .done(done5), .res(res5)
    );
    seq_mult #(.W(16)) u_dut16 (
        .clk(clk), .rst(rst_x), .start(start16), .sgn(sgn16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .res(res16)
    );

    logic [63:0] q8[$], q5[$], q16[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: sign/zero-extend, multiply in 64 bits, keep the low 2W bits.
    function automatic logic [63:0] ref_mult(input int w, input bit s,
                                             input logic [31:0] x, input logic [31:0] y);
        longint m  = (longint'(1) << w) - 1;
        longint sx = longint'(x) & m;
        longint sy = longint'(y) & m;
        longint p;
        if (s && x[w-1]) sx = sx - (longint'(1) << w);
        if (s && y[w-1]) sy = sy - (longint'(1) << w);
        p = sx * sy;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m = (32'd1 << w) - 32'd1;
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return m;
            2:       return 32'd1 << (w - 1);
            3:       return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    // Scoreboard monitors: sample on the falling edge.
    logic        rst_q8 = 1'b1, rst_qx = 1'b1;
    logic [15:0] last8  = '0;
    logic [9:0]  last5  = '0;
    logic [31:0] last16 = '0;
    logic [63:0] e8, e5, e16;
    always @(posedge clk) begin
        rst_q8 <= rst8;
        rst_qx <= rst_x;
    end

    always @(negedge clk) begin
        if (rst_q8) begin
            check("rst_res8", res8, 0);
            check("rst_busy8", busy8, 0);
            check("rst_done8", done8, 0);
            last8 = '0;
        end else if (done8) begin
            check("busy_with_done8", busy8, 0);
            if (q8.size() == 0) check("spurious_done8", done8, 0);
            else begin
                e8 = q8.pop_front();
                check("res8", res8, e8);
                last8 = e8[15:0];
            end
        end else if (res8 !== last8) check("res_stable8", res8, last8);
    end

    always @(negedge clk) begin
        if (rst_qx) begin
            check("rst_res5", res5, 0);
            last5 = '0;
        end else if (done5) begin
            check("busy_with_done5", busy5, 0);
            if (q5.size() == 0) check("spurious_done5", done5, 0);
            else begin
                e5 = q5.pop_front();
                check("res5", res5, e5);
                last5 = e5[9:0];
            end
        end else if (res5 !== last5) check("res_stable5", res5, last5);
    end

    always @(negedge clk) begin
        if (rst_qx) begin
            check("rst_res16", res16, 0);
            last16 = '0;
        end else if (done16) begin
            check("busy_with_done16", busy16, 0);
            if (q16.size() == 0) check("spurious_done16", done16, 0);
            else begin
                e16 = q16.pop_front();
                check("res16", res16, e16);
                last16 = e16[31:0];
            end
        end else if (res16 !== last16) check("res_stable16", res16, last16);
    end

    // Launch one operation; returns at the first busy cycle with operands scrambled.
    task automatic go8(input bit s, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start8 = 1'b1; sgn8 = s; a8 = x; b8 = y;
        q8.push_back(ref_mult(8, s, {24'b0, x}, {24'b0, y}));
        @(negedge clk);
        start8 = 1'b0; sgn8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic wait8(inout int nb);
        while (busy8 && nb < 64) begin
            nb++;
            @(negedge clk);
        end
    endtask

    task automatic run8(input string tag, input bit s, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] exp);
        int nb = 0;
        go8(s, x, y);
        wait8(nb);
        check({tag, "_busy_cycles"}, nb, 8);
        check({tag, "_done"}, done8, 1);
        check({tag, "_res"}, res8, exp);
        @(negedge clk);
        check({tag, "_done_pulse"}, done8, 0);
    endtask

    task automatic run5(input bit s, input logic [4:0] x, input logic [4:0] y, output int nb);
        @(negedge clk);
        start5 = 1'b1; sgn5 = s; a5 = x; b5 = y;
        q5.push_back(ref_mult(5, s, {27'b0, x}, {27'b0, y}));
        @(negedge clk);
        start5 = 1'b0; sgn5 = 1'($urandom); a5 = 5'($urandom); b5 = 5'($urandom);
        nb = 0;
        while (busy5 && nb < 64) begin
            nb++;
            @(negedge clk);
        end
    endtask

    task automatic run16(input bit s, input logic [15:0] x, input logic [15:0] y, output int nb);
        @(negedge clk);
        start16 = 1'b1; sgn16 = s; a16 = x; b16 = y;
        q16.push_back(ref_mult(16, s, {16'b0, x}, {16'b0, y}));
        @(negedge clk);
        start16 = 1'b0; sgn16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
        nb = 0;
        while (busy16 && nb < 64) begin
            nb++;
            @(negedge clk);
        end
    endtask

    bit          vs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  vx[6] = '{8'h80, 8'hFD, 8'h7F, 8'h00, 8'hFF, 8'hFF};
    logic [7:0]  vy[6] = '{8'h80, 8'h05, 8'h80, 8'hFF, 8'h02, 8'h02};
    logic [15:0] ve[6] = '{16'h4000, 16'hFFF1, 16'hC080, 16'h0000, 16'h01FE, 16'hFFFE};

    initial begin
        int nb;
        repeat (3) @(negedge clk);
        rst8 = 1'b0; rst_x = 1'b0;
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_res", res8, 0);

        run8("umax", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        for (int i = 0; i < 6; i++) run8($sformatf("corner%0d", i), vs[i], vx[i], vy[i], ve[i]);

        // Start during busy cycle 3 must be ignored.
        go8(1'b0, 8'd10, 8'd20);
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
        @(negedge clk);
        start8 = 1'b0;
        nb = 3;
        wait8(nb);
        check("ignore_busy_cycles", nb, 8);
        check("ignore_done", done8, 1);
        check("ignore_res", res8, 16'd200);
        repeat (12) @(negedge clk);
        check("ignore_idle", busy8, 0);

        // Start in the done cycle: second done exactly 9 clocks later.
        go8(1'b0, 8'd12, 8'd13);
        nb = 0;
        wait8(nb);
        check("b2b_first_done", done8, 1);
        start8 = 1'b1; sgn8 = 1'b1; a8 = 8'hF7; b8 = 8'd9;
        q8.push_back(ref_mult(8, 1'b1, 32'hF7, 32'd9));
        @(negedge clk);
        start8 = 1'b0;
        nb = 1;
        while (!done8 && nb < 50) begin
            @(negedge clk);
            nb++;
        end
        check("b2b_spacing", nb, 9);
        check("b2b_res", res8, 16'hFFAF);

        // Reset at busy cycle 4 aborts the operation.
        go8(1'b0, 8'd100, 8'd100);
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        q8.delete();
        @(negedge clk);
        rst8 = 1'b0;
        check("midrst_busy", busy8, 0);
        check("midrst_done", done8, 0);
        check("midrst_res", res8, 0);
        repeat (15) @(negedge clk);
        check("midrst_idle", busy8, 0);
        run8("post_rst", 1'b0, 8'd7, 8'd6, 16'd42);

        run5(1'b0, 5'd31, 5'd31, nb);
        check("w5_umax_busy", nb, 5);
        check("w5_umax_res", res5, 10'd961);

        fork
            begin
                int n5;
                for (int i = 0; i < 2000; i++) begin
                    run5(bit'(i % 2), 5'(pick(5)), 5'(pick(5)), n5);
                    check("w5_busy_cycles", n5, 5);
                end
            end
            begin
                int n16;
                for (int j = 0; j < 2000; j++) begin
                    run16(bit'(j % 2), 16'(pick(16)), 16'(pick(16)), n16);
                    check("w16_busy_cycles", n16, 16);
                end
            end
        join

        repeat (4) @(negedge clk);
        check("pending8", q8.size(), 0);
        check("pending5", q5.size(), 0);
        check("pending16", q16.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
